// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/stop sequencer issuing cpu_en pulses from the slow tick
// Optional breakpoint compare enabled by defining CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_stop,
    input  logic [1:0]       rate_sel,
    input  logic             cpu_halted,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
`endif
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } run_state_t;

    if (PC_W < 1 || CNT_W < 1) begin : g_param_check
        $error("cpu_run_ctrl: PC_W and CNT_W must be at least 1");
    end

    run_state_t state_q;
    logic [2:0] div;
    logic       prev_run;
    logic       prev_step;
    logic       prev_stop;
    logic       stop_req;
    logic       run_req;
    logic       step_req;
    logic [2:0] rate_mask;
    logic       tick_elig;

    // Edge requests resolved with stop > run > step.
    assign stop_req = btn_stop & ~prev_stop;
    assign run_req  = btn_run  & ~prev_run  & ~stop_req;
    assign step_req = btn_step & ~prev_step & ~stop_req & ~run_req;

    always_comb begin
        rate_mask = 3'b000;
        case (rate_sel)
            2'd0:    rate_mask = 3'b000;
            2'd1:    rate_mask = 3'b001;
            2'd2:    rate_mask = 3'b011;
            default: rate_mask = 3'b111;
        endcase
    end

    assign tick_elig = ((div & rate_mask) == rate_mask);
    assign state     = state_q;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic bp_skip;
    logic bp_match;
    assign bp_match = bp_valid & (pc == bp_addr) & ~bp_skip;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOP;
            cpu_en    <= 1'b0;
            step_cnt  <= '0;
            div       <= 3'd0;
            prev_run  <= 1'b0;
            prev_step <= 1'b0;
            prev_stop <= 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            bp_skip   <= 1'b0;
`endif
        end else begin
            prev_run  <= btn_run;
            prev_step <= btn_step;
            prev_stop <= btn_stop;
            cpu_en    <= 1'b0;

            if (cpu_en && (step_cnt != {CNT_W{1'b1}})) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end

            case (state_q)
                ST_STOP: begin
                    if (run_req || step_req) begin
                        if (cpu_halted) begin
                            state_q <= ST_HALT;
                        end else if (run_req) begin
                            state_q <= ST_RUN;
                            div     <= 3'd0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                            // Resuming lets the first pulse pass a breakpoint at the current pc.
                            bp_skip <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_STEP;
                        end
                    end
                end

                ST_RUN: begin
                    if (cpu_halted) begin
                        state_q <= ST_HALT;
                    end else if (stop_req) begin
                        state_q <= ST_STOP;
                    end else if (tick_in) begin
                        if (tick_elig) begin
                            div <= 3'd0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                            if (bp_match) begin
                                state_q <= ST_STOP;
                            end else begin
                                cpu_en  <= ~cpu_en;
                                bp_skip <= 1'b0;
                            end
`else
                            // Gating with the current pulse keeps cpu_en from going high twice in a row.
                            cpu_en <= ~cpu_en;
`endif
                        end else begin
                            div <= div + 3'd1;
                        end
                    end
                end

                ST_STEP: begin
                    if (cpu_halted) begin
                        state_q <= ST_HALT;
                    end else begin
                        cpu_en  <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end

                default: begin
                    if (stop_req) begin
                        state_q <= ST_STOP;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/stop sequencer for the minicpu clock-enable.
- Consumes the 1-cycle slow tick pulse (50 MHz base, one pulse per 50_000_000 cycles) and front-panel buttons.
- Issues single-cycle cpu_en pulses that advance the CPU, at a selectable fraction of the tick rate.
- Tracks CPU halt and counts issued steps; sits between the slow tick generator and the CPU core.

Parameters:
- CNT_W, 16, width of the issued-step counter (saturating).
- PC_W, 8, width of the pc/breakpoint compare (used only with the optional feature).

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  reset; asynchronous, active-high
- tick_in  in  1  one-cycle pulse from the slow tick generator
- btn_run  in  1  synchronised, debounced level; rising edge = run request
- btn_step  in  1  synchronised, debounced level; rising edge = single-step request
- btn_stop  in  1  synchronised, debounced level; rising edge = stop request
- rate_sel  in  2  run rate: 0 = every tick, 1 = every 2nd, 2 = every 4th, 3 = every 8th tick
- cpu_halted  in  1  level from the CPU, asserted after a HLT instruction
- cpu_en  out  1  one-cycle CPU advance enable
- state  out  2  00 STOP, 01 RUN, 10 STEP, 11 HALT
- step_cnt  out  CNT_W  number of cpu_en pulses issued since reset

Behaviour:
- Reset values: state = STOP, cpu_en = 0, step_cnt = 0, tick divider count = 0, button edge-history registers = 0.
- All outputs are registered.
- Edge detect: each button has a previous-value register; a request is level & ~prev, valid for one cycle.
- A button held high through reset release produces an edge on the first clock after reset.
- Request priority when simultaneous: stop > run > step.
- Precedence: cpu_halted beats every button request except in HALT itself.

STOP:
- run request -> RUN, tick divider cleared.
- step request -> STEP.
- Otherwise hold; cpu_en = 0.

RUN:
- tick_in increments a 3-bit divider.
- When the divider's pre-increment value has its low rate_sel bits all ones (rate 0: always), the divider clears.
- In that case, cpu_en = 1 in the following cycle.
- So rate 0 gives cpu_en exactly 1 cycle after each tick_in; rate 3 gives cpu_en after the 8th, 16th, ... tick.
- rate_sel changes take effect at the next tick; the divider is not cleared.
- stop request -> STOP, no further cpu_en. If a stop request and an eligible tick occur in the same cycle, no cpu_en is issued.
- cpu_halted = 1 -> HALT (checked every cycle, before tick processing).

STEP:
- Does not wait for a tick: cpu_en = 1 in the cycle after entry.
- Returns to STOP in that same cycle.
- Exactly one pulse per step request; step requests while in STEP are ignored.
- cpu_halted = 1 on entry -> HALT, no pulse.

HALT:
- cpu_en = 0; run and step requests are ignored.
- stop request -> STOP (acknowledge). If cpu_halted is still high, the next run/step re-enters HALT without issuing a pulse.

General rules:
- cpu_en is never high for two consecutive cycles.
- step_cnt increments on every cycle where cpu_en = 1 and saturates at 2^CNT_W-1; it does not wrap.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; any pending cpu_en is dropped.

Optional Feature:
- Macro CPU_RUN_CTRL_BREAKPOINT_EN.
- With it defined:
  - Adds ports pc (in, PC_W, current CPU program counter), bp_addr (in, PC_W) and bp_valid (in, 1).
  - In RUN, when a pulse is due and bp_valid & (pc == bp_addr), no cpu_en is issued and state goes to STOP.
  - STEP always issues its pulse, so the user can step past a breakpoint.
  - A subsequent run request resumes, and the breakpoint at the same pc is ignored for exactly one pulse.
- Without it: the ports are absent and RUN never self-stops except via cpu_halted.

Test Plan:
- Reset, rate_sel = 0, run edge, 5 tick_in pulses 10 cycles apart -> 5 cpu_en pulses, each exactly 1 cycle after its tick; state 01; step_cnt = 5.
- rate_sel = 2, RUN, 12 ticks -> cpu_en after ticks 4, 8, 12 only; step_cnt = 3.
- STOP, three separated step edges with no ticks -> 3 single-cycle cpu_en pulses; state returns to 00 after each; step_cnt = 3.
- RUN with stop and run edges asserted in the same cycle -> state 00; a tick arriving in that cycle produces no cpu_en.
- RUN, assert cpu_halted -> state 11 next cycle, ticks produce no cpu_en, run edge ignored; stop edge -> 00.
- Preload step_cnt near max (CNT_W = 4 build), issue 20 steps -> step_cnt stops at 15. Then assert rst mid-RUN between tick and cpu_en -> no cpu_en, all outputs 0.
